// File: rtl/act_skew_feeder.sv
// Activation skew feeder for a weight-stationary PE array: lane r is delayed r+1 cycles,
// the pipeline is zero-flushed after the last beat, and done pulses once the flush drains.
module act_skew_feeder #(
  parameter int ROWS         = 4,
  parameter int ACT_WIDTH    = 16,
  parameter int OP_SIG_WIDTH = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*ACT_WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic [ROWS*ACT_WIDTH-1:0] out_act,
  output logic [ROWS-1:0]           out_vld,
  output logic [OP_SIG_WIDTH-1:0]   op_sig_out,
  output logic [CNT_WIDTH-1:0]      beat_cnt,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int            FW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS - 1);

  logic [1:0]           state_q, state_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_STREAM);
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          // A new stream restarts the count at 1; within a stream it saturates.
          if (state_q == S_IDLE)     cnt_d = CNT_WIDTH'(1);
          else if (cnt_q != '1)      cnt_d = cnt_q + CNT_WIDTH'(1);
          if (in_last) begin
            state_d = S_FLUSH;
            fcnt_d  = '0;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_FLUSH: begin
        if (fcnt_q == FLUSH_LAST) state_d = S_DONE;
        else                      fcnt_d  = fcnt_q + FW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep register updates independent of statement order.
    if (!reset) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0][ACT_WIDTH-1:0] dat_q;
    logic [r:0]                vld_q;

    always_ff @(posedge clk or negedge reset) begin
      // NOTE: the skew chains are reset as well, so a mid-stream reset drops in-flight data.
      if (!reset) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q[0] <= accept ? in_data[r*ACT_WIDTH +: ACT_WIDTH] : '0;
        vld_q[0] <= accept;
        for (int s = 1; s <= r; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign out_act[r*ACT_WIDTH +: ACT_WIDTH] = dat_q[r];
    assign out_vld[r]                        = vld_q[r];
  end

  assign op_sig_out = '0;
  assign beat_cnt   = cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: a ROWS=4 instance and a ROWS=1 instance,
// expected lane data/arrival edges and done events are queued at issue time.
module tb_act_skew_feeder;

  localparam int AW = 16;
  localparam int CW = 16;
  localparam int OW = 3;

  typedef struct { logic [AW-1:0] data; int edge_no; } lane_exp_t;
  typedef struct { logic [CW-1:0] cnt;  int edge_no; } done_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic            in_valid4 = 1'b0, in_last4 = 1'b0, in_ready4;
  logic [4*AW-1:0] in_data4  = '0,   out_act4;
  logic [3:0]      out_vld4;
  logic [OW-1:0]   op_sig4;
  logic [CW-1:0]   beat_cnt4;
  logic            busy4, done4;

  logic            in_valid1 = 1'b0, in_last1 = 1'b0, in_ready1;
  logic [AW-1:0]   in_data1  = '0,   out_act1;
  logic [0:0]      out_vld1;
  logic [OW-1:0]   op_sig1;
  logic [CW-1:0]   beat_cnt1;
  logic            busy1, done1;

  act_skew_feeder #(.ROWS(4), .ACT_WIDTH(AW), .OP_SIG_WIDTH(OW), .CNT_WIDTH(CW)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_last(in_last4), .out_act(out_act4), .out_vld(out_vld4),
    .op_sig_out(op_sig4), .beat_cnt(beat_cnt4), .busy(busy4), .done(done4));

  act_skew_feeder #(.ROWS(1), .ACT_WIDTH(AW), .OP_SIG_WIDTH(OW), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_last(in_last1), .out_act(out_act1), .out_vld(out_vld1),
    .op_sig_out(op_sig1), .beat_cnt(beat_cnt1), .busy(busy1), .done(done1));

  int errs   = 0;
  int checks = 0;
  int edge_n = 0;

  lane_exp_t lq4 [4][$];
  lane_exp_t lq1 [$];
  done_exp_t dq4 [$];
  done_exp_t dq1 [$];
  lane_exp_t e4, e1;
  done_exp_t f4, f1;

  // Reference model of the handshake for whichever instance is being driven.
  bit          use1      = 1'b0;
  int          idle_edge = 0;
  bit          in_stream = 1'b0;
  logic [CW-1:0] cnt_m   = '0;

  logic          cur_ready, cur_busy;
  logic [CW-1:0] cur_cnt;
  assign cur_ready = use1 ? in_ready1 : in_ready4;
  assign cur_busy  = use1 ? busy1     : busy4;
  assign cur_cnt   = use1 ? beat_cnt1 : beat_cnt4;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int pending();
    return lq4[0].size() + lq4[1].size() + lq4[2].size() + lq4[3].size()
         + lq1.size() + dq4.size() + dq1.size();
  endfunction

  // Monitor for the 4-row instance.
  always @(negedge clk) begin
    if (reset) begin
      for (int r = 0; r < 4; r++) begin
        if (out_vld4[r]) begin
          if (lq4[r].size() == 0) begin
            check("lane4_unexpected_vld", 64'(out_vld4[r]), 64'd0);
          end else begin
            e4 = lq4[r].pop_front();
            check("lane4_data", 64'(out_act4[r*AW +: AW]), 64'(e4.data));
            check("lane4_edge", 64'(edge_n), 64'(e4.edge_no));
          end
        end else begin
          check("lane4_bubble_zero", 64'(out_act4[r*AW +: AW]), 64'd0);
        end
      end
      check("op_sig4", 64'(op_sig4), 64'd0);
      if (done4) begin
        if (dq4.size() == 0) begin
          check("done4_unexpected", 64'(done4), 64'd0);
        end else begin
          f4 = dq4.pop_front();
          check("done4_edge", 64'(edge_n), 64'(f4.edge_no));
          check("done4_beat_cnt", 64'(beat_cnt4), 64'(f4.cnt));
          check("done4_vld_clear", 64'(out_vld4), 64'd0);
        end
      end
    end
  end

  // Monitor for the 1-row instance.
  always @(negedge clk) begin
    if (reset) begin
      if (out_vld1[0]) begin
        if (lq1.size() == 0) begin
          check("lane1_unexpected_vld", 64'(out_vld1), 64'd0);
        end else begin
          e1 = lq1.pop_front();
          check("lane1_data", 64'(out_act1), 64'(e1.data));
          check("lane1_edge", 64'(edge_n), 64'(e1.edge_no));
        end
      end else begin
        check("lane1_bubble_zero", 64'(out_act1), 64'd0);
      end
      check("op_sig1", 64'(op_sig1), 64'd0);
      if (done1) begin
        if (dq1.size() == 0) begin
          check("done1_unexpected", 64'(done1), 64'd0);
        end else begin
          f1 = dq1.pop_front();
          check("done1_edge", 64'(edge_n), 64'(f1.edge_no));
          check("done1_beat_cnt", 64'(beat_cnt1), 64'(f1.cnt));
          check("done1_vld_clear", 64'(out_vld1), 64'd0);
        end
      end
    end
  end

  task automatic set_in(input logic v, input logic [4*AW-1:0] d, input logic last);
    if (use1) begin
      in_valid1 = v; in_data1 = d[AW-1:0]; in_last1 = last;
    end else begin
      in_valid4 = v; in_data4 = d;         in_last4 = last;
    end
  endtask

  // Bubbles carry random data and in_last=1, both of which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, {$urandom, $urandom}, 1'b1);
      @(negedge clk);
    end
  endtask

  // Present one beat, hold it while the feeder is flushing, queue its expected outputs.
  task automatic beat(input logic [4*AW-1:0] d, input logic last);
    int        rows   = use1 ? 1 : 4;
    int        waited = 0;
    lane_exp_t le;
    done_exp_t de;
    set_in(1'b1, d, last);
    while (edge_n < idle_edge && waited < 40) begin
      check("ready_low_while_flushing", 64'(cur_ready), 64'd0);
      check("busy_while_flushing", 64'(cur_busy), 64'd1);
      check("beat_cnt_hold", 64'(cur_cnt), 64'(cnt_m));
      @(negedge clk);
      waited++;
    end
    check("ready_high", 64'(cur_ready), 64'd1);
    if (!in_stream)        cnt_m = CW'(1);
    else if (cnt_m != '1)  cnt_m = cnt_m + CW'(1);
    for (int r = 0; r < rows; r++) begin
      le.data    = d[r*AW +: AW];
      le.edge_no = edge_n + 1 + r;
      if (use1) lq1.push_back(le);
      else      lq4[r].push_back(le);
    end
    if (last) begin
      de.cnt     = cnt_m;
      de.edge_no = edge_n + 1 + rows;
      if (use1) dq1.push_back(de);
      else      dq4.push_back(de);
      idle_edge = edge_n + 1 + rows + 1;
      in_stream = 1'b0;
    end else begin
      in_stream = 1'b1;
    end
    @(negedge clk);
    check("beat_cnt", 64'(cur_cnt), 64'(cnt_m));
    check("busy_after_accept", 64'(cur_busy), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(pending()), 64'd0);
  endtask

  initial begin
    // Reset values.
    #1;
    check("rst_in_ready4", 64'(in_ready4), 64'd1);
    check("rst_out_act4",  out_act4,       64'd0);
    check("rst_out_vld4",  64'(out_vld4),  64'd0);
    check("rst_op_sig4",   64'(op_sig4),   64'd0);
    check("rst_beat_cnt4", 64'(beat_cnt4), 64'd0);
    check("rst_busy4",     64'(busy4),     64'd0);
    check("rst_done4",     64'(done4),     64'd0);
    check("rst_in_ready1", 64'(in_ready1), 64'd1);
    check("rst_busy1",     64'(busy1),     64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // T1 two-beat stream, then T4: next beat held high through FLUSH/DONE.
    beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
    beat({16'd8, 16'd7, 16'd6, 16'd5}, 1'b1);
    beat({16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 1'b1);
    idle(2);

    // T2 single beat from IDLE.
    beat({16'd9, 16'd9, 16'd9, 16'd9}, 1'b1);
    idle(6);
    check("t2_idle_after_done", 64'(busy4), 64'd0);

    // T3 bubble between two beats.
    beat({16'h0013, 16'h0012, 16'h0011, 16'h0010}, 1'b0);
    idle(1);
    beat({16'h0023, 16'h0022, 16'h0021, 16'h0020}, 1'b1);
    idle(7);

    // T5 asynchronous reset in the middle of a stream.
    beat({16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1'b0);
    beat({16'h5555, 16'h6666, 16'h7777, 16'h8888}, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("t5_out_act",  out_act4,       64'd0);
    check("t5_out_vld",  64'(out_vld4),  64'd0);
    check("t5_beat_cnt", 64'(beat_cnt4), 64'd0);
    check("t5_busy",     64'(busy4),     64'd0);
    check("t5_in_ready", 64'(in_ready4), 64'd1);
    check("t5_done",     64'(done4),     64'd0);
    set_in(1'b0, '0, 1'b0);
    for (int r = 0; r < 4; r++) lq4[r].delete();
    dq4.delete();
    in_stream = 1'b0;
    idle_edge = 0;
    cnt_m     = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    beat({16'h0F0F, 16'h00F0, 16'hF000, 16'h000F}, 1'b1);
    idle(7);
    drain();

    // T6 single-row instance with negative values.
    use1      = 1'b1;
    in_stream = 1'b0;
    idle_edge = 0;
    cnt_m     = '0;
    check("t6_rst_beat_cnt1", 64'(beat_cnt1), 64'd0);
    beat(64'h8000, 1'b0);
    beat(64'hFFFF, 1'b1);
    beat(64'h7FFF, 1'b1);
    idle(4);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
